// File: rtl/collision_detector_pkg.sv
// Shared game definitions for the collision detector and its neighbours.
// BIRD_X lives here so the obstacle generator's score compare uses the same bird position.
package collision_detector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } game_state_e;

  typedef enum logic [1:0] {
    SRC_PIPE1  = 2'd0,
    SRC_PIPE2  = 2'd1,
    SRC_PIPE3  = 2'd2,
    SRC_BOUNDS = 2'd3
  } hit_src_e;

  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned OFFSCREEN_X = 680;
  localparam int unsigned BIRD_X      = 100;

endpackage

// File: rtl/collision_detector_pipe_hit_check.sv
// Combinational test of one pipe (x, gap-centre y) against the bird's y position.
// All arithmetic is done in 11 bits so the sums cannot wrap.
module pipe_hit_check
  import collision_detector_pkg::*;
#(
  parameter int unsigned BIRD_SIZE = 16,
  parameter int unsigned PIPE_W    = 40,
  parameter int unsigned GAP_HALF  = 50
) (
  input  logic [9:0] obs_x,
  input  logic [9:0] obs_y,
  input  logic [9:0] bird_y,
  output logic       hit
);

  localparam logic [10:0] X_LO   = 11'(BIRD_X);
  localparam logic [10:0] X_HI   = 11'(BIRD_X + BIRD_SIZE - 1);
  localparam logic [10:0] PW_M1  = 11'(PIPE_W - 1);
  localparam logic [10:0] GH     = 11'(GAP_HALF);
  localparam logic [10:0] BS     = 11'(BIRD_SIZE);

  logic [10:0] x_ext;
  logic [10:0] y_ext;
  logic [10:0] b_ext;
  logic        overlap;
  logic        outside_gap;

  assign x_ext = {1'b0, obs_x};
  assign y_ext = {1'b0, obs_y};
  assign b_ext = {1'b0, bird_y};

  // Edge pixels count as overlap; touching a gap edge exactly does not.
  assign overlap     = (x_ext <= X_HI) && ((x_ext + PW_M1) >= X_LO);
  assign outside_gap = ((b_ext + GH) < y_ext) || ((b_ext + BS) > (y_ext + GH));
  assign hit         = overlap && outside_gap;

endmodule

// File: rtl/collision_detector.sv
// Game state machine: snapshots positions on each physics tick, scans the three pipes and the
// screen bounds one per cycle through a shared checker, and sequences idle/play/hit/over.
module collision_detector
  import collision_detector_pkg::*;
#(
  parameter int unsigned BIRD_SIZE  = 16,
  parameter int unsigned PIPE_W     = 40,
  parameter int unsigned GAP_HALF   = 50,
  parameter int unsigned CEIL_Y     = 0,
  parameter int unsigned FLOOR_Y    = 460,
  parameter int unsigned HOLD_TICKS = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       start,
  input  logic [9:0] bird_y,
  input  logic [6:0] score,
  input  logic [9:0] obs1x,
  input  logic [9:0] obs1y,
  input  logic [9:0] obs2x,
  input  logic [9:0] obs2y,
  input  logic [9:0] obs3x,
  input  logic [9:0] obs3y,
  output logic       reset_physics,
  output logic       playing,
  output logic       game_over,
  output logic       hit,
  output logic [1:0] hit_src,
  output logic [6:0] high_score,
  output logic       check_done
);

  localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);

  game_state_e       state;
  hit_src_e          hit_src_q;
  hit_src_e          found_src;
  hit_src_e          cur_src;
  logic              found;
  logic [2:0]        scan_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              start_armed;
  logic [2:0][9:0]   snap_x;
  logic [2:0][9:0]   snap_y;
  logic [9:0]        snap_bird;

  logic [9:0]  mux_x;
  logic [9:0]  mux_y;
  logic        pipe_hit;
  logic [10:0] bird_ext;
  logic        bounds_hit;
  logic        src_hit;

  // Scan slots 1..3 select pipes 1..3; slot 4 is the bounds check.
  always_comb begin
    mux_x = snap_x[0];
    mux_y = snap_y[0];
    case (scan_cnt)
      3'd2: begin
        mux_x = snap_x[1];
        mux_y = snap_y[1];
      end
      3'd3: begin
        mux_x = snap_x[2];
        mux_y = snap_y[2];
      end
      default: ;
    endcase
  end

  pipe_hit_check #(
    .BIRD_SIZE (BIRD_SIZE),
    .PIPE_W    (PIPE_W),
    .GAP_HALF  (GAP_HALF)
  ) u_pipe_hit_check (
    .obs_x  (mux_x),
    .obs_y  (mux_y),
    .bird_y (snap_bird),
    .hit    (pipe_hit)
  );

  // bird_y < CEIL_Y written as bird_y + 1 <= CEIL_Y so a zero ceiling stays a live compare.
  assign bird_ext   = {1'b0, snap_bird};
  assign bounds_hit = ((bird_ext + 11'd1) <= 11'(CEIL_Y)) ||
                      ((bird_ext + 11'(BIRD_SIZE)) > 11'(FLOOR_Y));
  assign src_hit    = (scan_cnt == 3'd4) ? bounds_hit : pipe_hit;
  assign cur_src    = hit_src_e'(scan_cnt[1:0] - 2'd1);
  assign hit_src    = hit_src_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      reset_physics <= 1'b0;
      playing       <= 1'b0;
      game_over     <= 1'b0;
      hit           <= 1'b0;
      hit_src_q     <= SRC_PIPE1;
      high_score    <= '0;
      check_done    <= 1'b0;
      found         <= 1'b0;
      found_src     <= SRC_PIPE1;
      scan_cnt      <= '0;
      hold_cnt      <= '0;
      start_armed   <= 1'b0;
      snap_x        <= '0;
      snap_y        <= '0;
      snap_bird     <= '0;
    end else begin
      reset_physics <= 1'b0;
      check_done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            reset_physics <= 1'b1;
            playing       <= 1'b1;
            state         <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (scan_cnt == 3'd0) begin
            if (tick) begin
              snap_x    <= {obs3x, obs2x, obs1x};
              snap_y    <= {obs3y, obs2y, obs1y};
              snap_bird <= bird_y;
              found     <= 1'b0;
              scan_cnt  <= 3'd1;
            end
          end else if (scan_cnt != 3'd5) begin
            // First hitting source wins, giving pipe1 the highest priority.
            if (src_hit && !found) begin
              found     <= 1'b1;
              found_src <= cur_src;
            end
            scan_cnt <= scan_cnt + 3'd1;
          end else begin
            scan_cnt   <= 3'd0;
            check_done <= 1'b1;
            if (found) begin
              state     <= ST_HIT;
              playing   <= 1'b0;
              hit       <= 1'b1;
              hit_src_q <= found_src;
              hold_cnt  <= HOLD_W'(HOLD_TICKS);
            end
          end
        end
        ST_HIT: begin
          if (tick) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
            if (hold_cnt == HOLD_W'(1)) begin
              state       <= ST_OVER;
              game_over   <= 1'b1;
              start_armed <= 1'b0;
              if (score > high_score) high_score <= score;
            end
          end
        end
        ST_OVER: begin
          // A button still held from the crash must be released before it can restart.
          if (!start) begin
            start_armed <= 1'b1;
          end else if (start_armed) begin
            reset_physics <= 1'b1;
            playing       <= 1'b1;
            game_over     <= 1'b0;
            hit           <= 1'b0;
            hit_src_q     <= SRC_PIPE1;
            start_armed   <= 1'b0;
            state         <= ST_PLAY;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_detector.sv
// Bench for collision_detector: a game-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_collision_detector;

  localparam int BX = 100, BS = 16, PW = 40, GH = 50, CEIL = 0, FLOOR = 460, HOLD = 60;
  localparam int M_IDLE = 0, M_PLAY = 1, M_HIT = 2, M_OVER = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [9:0] bird_y = '0;
  logic [6:0] score = '0;
  logic [9:0] obs1x = 10'd680, obs1y = '0, obs2x = 10'd680, obs2y = '0, obs3x = 10'd680, obs3y = '0;
  logic       reset_physics, playing, game_over, hit, check_done;
  logic [1:0] hit_src;
  logic [6:0] high_score;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  collision_detector dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .tick          (tick),
    .start         (start),
    .bird_y        (bird_y),
    .score         (score),
    .obs1x         (obs1x),
    .obs1y         (obs1y),
    .obs2x         (obs2x),
    .obs2y         (obs2y),
    .obs3x         (obs3x),
    .obs3y         (obs3y),
    .reset_physics (reset_physics),
    .playing       (playing),
    .game_over     (game_over),
    .hit           (hit),
    .hit_src       (hit_src),
    .high_score    (high_score),
    .check_done    (check_done)
  );

  // ---------------- reference model ----------------
  int m_state = M_IDLE;
  int m_src = 0, m_hs = 0, scan_left = 0, pend = -1, hold_left = 0;
  bit m_rp = 0, m_play = 0, m_over = 0, m_hit = 0, m_done = 0, armed = 0;

  function automatic bit pipe_hits(int x, int y, int b);
    bit overlap, outside;
    overlap = (x <= BX + BS - 1) && (x + PW - 1 >= BX);
    outside = (b + GH < y) || (b + BS > y + GH);
    return overlap && outside;
  endfunction

  function int first_hit();
    int b;
    b = int'(bird_y);
    if (pipe_hits(int'(obs1x), int'(obs1y), b)) return 0;
    if (pipe_hits(int'(obs2x), int'(obs2y), b)) return 1;
    if (pipe_hits(int'(obs3x), int'(obs3y), b)) return 2;
    if (b < CEIL || b + BS > FLOOR) return 3;
    return -1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_state = M_IDLE; m_src = 0; m_hs = 0; scan_left = 0; pend = -1; hold_left = 0;
      m_rp = 0; m_play = 0; m_over = 0; m_hit = 0; m_done = 0; armed = 0;
    end else begin
      m_rp = 0;
      m_done = 0;
      case (m_state)
        M_IDLE: if (start) begin
          m_rp = 1; m_play = 1; m_state = M_PLAY;
        end
        M_PLAY: begin
          if (scan_left > 0) begin
            scan_left--;
            if (scan_left == 0) begin
              m_done = 1;
              if (pend >= 0) begin
                m_state = M_HIT; m_hit = 1; m_src = pend; m_play = 0; hold_left = HOLD;
              end
            end
          end else if (tick) begin
            pend = first_hit();
            scan_left = 5;
          end
        end
        M_HIT: if (tick) begin
          hold_left--;
          if (hold_left == 0) begin
            m_state = M_OVER; m_over = 1; armed = 0;
            if (int'(score) > m_hs) m_hs = int'(score);
          end
        end
        default: begin
          if (!start) armed = 1;
          else if (armed) begin
            m_rp = 1; m_play = 1; m_over = 0; m_hit = 0; m_src = 0; armed = 0;
            m_state = M_PLAY;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    n_checks++;
    if (reset_physics !== m_rp || playing !== m_play || game_over !== m_over ||
        hit !== m_hit || check_done !== m_done || int'(high_score) != m_hs ||
        (m_hit && int'(hit_src) != m_src)) begin
      n_errors++;
      $display("FAIL model_cmp t=%0t got rp=%b play=%b over=%b hit=%b src=%0d done=%b hs=%0d want rp=%b play=%b over=%b hit=%b src=%0d done=%b hs=%0d",
               $time, reset_physics, playing, game_over, hit, hit_src, check_done, high_score,
               m_rp, m_play, m_over, m_hit, m_src, m_done, m_hs);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
    end
  endtask

  task automatic set_obs(input int x1, input int y1, input int x2, input int y2,
                         input int x3, input int y3);
    obs1x = 10'(x1); obs1y = 10'(y1);
    obs2x = 10'(x2); obs2y = 10'(y2);
    obs3x = 10'(x3); obs3y = 10'(y3);
  endtask

  task automatic scan_tick(input string name, input bit exp_hit, input int exp_src);
    int lat;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    lat = -1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (check_done && lat < 0) lat = n;
    end
    chk({name, "_latency"}, lat, 5);
    chk({name, "_hit"}, int'(hit), int'(exp_hit));
    chk({name, "_playing"}, int'(playing), int'(!exp_hit));
    if (exp_hit) chk({name, "_src"}, int'(hit_src), exp_src);
  endtask

  task automatic hold_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic restart(input string name);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk({name, "_rp_pulse"}, int'(reset_physics), 1);
    chk({name, "_playing"}, int'(playing), 1);
    chk({name, "_hit_clear"}, int'(hit), 0);
    chk({name, "_over_clear"}, int'(game_over), 0);
    start = 1'b0;
    @(negedge clk);
    chk({name, "_rp_one_cycle"}, int'(reset_physics), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit saw_done;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_playing", int'(playing), 0);
    chk("reset_hit", int'(hit), 0);
    chk("reset_hs", int'(high_score), 0);

    start = 1'b1;
    @(negedge clk);
    chk("start_rp", int'(reset_physics), 1);
    chk("start_playing", int'(playing), 1);
    chk("start_hit", int'(hit), 0);
    chk("start_hs", int'(high_score), 0);
    start = 1'b0;
    @(negedge clk);
    chk("start_rp_one_cycle", int'(reset_physics), 0);

    // game 1: clear pass, then pipe1 floor-side strike
    set_obs(110, 250, 680, 0, 680, 0);
    bird_y = 10'd230;
    scan_tick("g1_clear", 1'b0, 0);
    bird_y = 10'd300;
    scan_tick("g1_pipe1", 1'b1, 0);
    score = 7'd12;
    hold_ticks(HOLD - 1);
    chk("g1_over_early", int'(game_over), 0);
    start = 1'b1;
    hold_ticks(1);
    chk("g1_over", int'(game_over), 1);
    chk("g1_hs", int'(high_score), 12);
    repeat (10) @(negedge clk);
    chk("held_start_over", int'(game_over), 1);
    chk("held_start_playing", int'(playing), 0);
    restart("r1");

    // game 2: pipe2 beats bounds
    set_obs(680, 0, 100, 250, 680, 0);
    bird_y = 10'd450;
    scan_tick("g2_prio", 1'b1, 1);
    score = 7'd7;
    hold_ticks(HOLD);
    chk("g2_over", int'(game_over), 1);
    chk("g2_hs_kept", int'(high_score), 12);
    restart("r2");

    // game 3: floor only
    set_obs(680, 0, 680, 0, 680, 0);
    bird_y = 10'd445;
    scan_tick("g3_floor", 1'b1, 3);
    hold_ticks(HOLD);
    restart("r3");

    // game 4/5: gap edges
    set_obs(100, 200, 680, 0, 680, 0);
    bird_y = 10'd150;
    scan_tick("gap_top_edge", 1'b0, 0);
    bird_y = 10'd234;
    scan_tick("gap_bot_edge", 1'b0, 0);
    bird_y = 10'd149;
    scan_tick("gap_top_in", 1'b1, 0);
    hold_ticks(HOLD);
    restart("r4");
    bird_y = 10'd235;
    scan_tick("gap_bot_in", 1'b1, 0);
    hold_ticks(HOLD);
    restart("r5");

    // asynchronous reset mid-scan
    set_obs(680, 0, 680, 0, 680, 0);
    bird_y = 10'd230;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async_playing", int'(playing), 0);
    chk("async_hit", int'(hit), 0);
    chk("async_hs", int'(high_score), 0);
    chk("async_over", int'(game_over), 0);
    chk("async_done", int'(check_done), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // tick coinciding with start in IDLE is ignored
    set_obs(110, 250, 680, 0, 680, 0);
    bird_y = 10'd300;
    start = 1'b1;
    tick = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tick = 1'b0;
    chk("idle_start_playing", int'(playing), 1);
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (check_done) saw_done = 1'b1;
    end
    chk("idle_tick_ignored", int'(saw_done), 0);
    scan_tick("after_idle", 1'b1, 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/collision_detector.md
Name: collision_detector

Overview:
- Consumes the obstacle generator's per-tick outputs (three pipe x/y pairs, score) together with the bird's y position.
- Decides whether the bird has struck a pipe, the floor or the ceiling.
- Runs the game state machine (idle/play/hit/over) and drives the generator's reset_physics strobe, a freeze/play flag and a best-score register.
- Sits between the obstacle generator, the bird physics block and the VGA/score display.

Parameters:
- BIRD_X, 100, fixed bird left x (pixels)
- BIRD_SIZE, 16, bird square side (pixels)
- PIPE_W, 40, pipe width; a pipe spans x..x+PIPE_W-1
- GAP_HALF, 50, half-height of the pipe gap, centred on obsNy
- CEIL_Y, 0, bird_y below this value is a ceiling hit
- FLOOR_Y, 460, bird_y+BIRD_SIZE above this value is a floor hit
- HOLD_TICKS, 60, ticks spent in HIT before OVER

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle physics-step strobe (same strobe that clocks obstacle motion)
- start  in  1  synchronised flap/start button, level
- bird_y  in  10  bird top y
- score  in  7  current score from the obstacle generator
- obs1x, obs1y, obs2x, obs2y, obs3x, obs3y  in  10 each  pipe x and gap-centre y
- reset_physics  out  1  one-cycle pulse to the generator and physics
- playing  out  1  high only in PLAY; physics/obstacles freeze when low
- game_over  out  1  high in OVER
- hit  out  1  high in HIT and OVER
- hit_src  out  2  0=pipe1, 1=pipe2, 2=pipe3, 3=floor/ceiling; valid while hit=1
- high_score  out  7  best score since reset
- check_done  out  1  one-cycle pulse when a scan completes

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, all outputs 0, high_score=0, scan idle, hold counter=0.
- States:
  - IDLE: on start=1, pulse reset_physics for 1 cycle, go to PLAY.
  - PLAY: playing=1. On tick, snapshot all ten position inputs, then scan one source per cycle: pipe1, pipe2, pipe3, bounds (cycles 1..4 after tick). check_done pulses in cycle 5.
    - If any source hit, go to HIT in cycle 5. hit_src = lowest-index hitting source (pipe1 highest priority, bounds lowest).
    - Ticks arriving while a scan is active are ignored (tick spacing is guaranteed >5 cycles).
  - HIT: playing=0, hit=1. Hold counter counts ticks. When the count reaches HOLD_TICKS, go to OVER and load high_score=max(high_score, score) on that transition.
  - OVER: game_over=1. Requires start to be seen low then high (edge-qualified), so a held button cannot restart. On that edge, pulse reset_physics, clear hit/hit_src, go to PLAY.
- Pipe hit test, computed in 11-bit unsigned to avoid wrap:
  - Horizontal overlap: obsx <= BIRD_X+BIRD_SIZE-1 AND obsx+PIPE_W-1 >= BIRD_X.
  - Outside gap: bird_y+GAP_HALF < obsy OR bird_y+BIRD_SIZE > obsy+GAP_HALF.
  - A pipe hits only when both hold.
  - obsx >= 640 (parked offscreen, e.g. 680) never overlaps with default parameters; no explicit enable is used.
- Bounds hit: bird_y < CEIL_Y OR bird_y+BIRD_SIZE > FLOOR_Y. With CEIL_Y=0 only the floor term is live.
- Touching boundaries: overlap is inclusive at the edge pixels. Bird exactly at gap edges (bird_y = obsy-GAP_HALF, or bird_y+BIRD_SIZE = obsy+GAP_HALF) is not a hit.
- Simultaneous tick and start in IDLE: start wins; the first scan happens on the next tick.
- reset_n asserted mid-scan or mid-HIT: immediate return to reset values; high_score also clears.

Decomposition:
- Shared package: game-state encoding (IDLE/PLAY/HIT/OVER), hit_src encoding, SCREEN_W=640, OFFSCREEN_X=680, BIRD_X. BIRD_X moves there so the obstacle generator's score compare and this block agree.
- One natural sub-module, pipe_hit_check: combinational test of one (x,y) against bird_y with the parameters above. It is instantiated once and time-multiplexed by the scan counter.

Test Plan:
- Reset then start=1: reset_physics pulses exactly 1 cycle, playing=1, hit=0, high_score=0.
- PLAY, obs1x=110, obs1y=250, bird_y=230, tick: check_done 5 cycles later, no hit. Then bird_y=300 (300+16>300) with tick: hit=1, hit_src=0, playing=0.
- Pipe2 and bounds both hitting (obs2x=100, obs2y=250, bird_y=450): hit_src=1 (priority). Repeat with all pipes x=680 and bird_y=445 (445+16>460): hit_src=3.
- Gap-edge case: obs1x=100, obs1y=200, bird_y=150, then bird_y=234: neither hits. bird_y=149 and bird_y=235 both hit.
- HIT with score=12, apply 60 ticks: game_over=1 on the 60th, high_score=12. Next game ends with score=7: high_score stays 12.
- OVER with start held high: no restart. Release, then press: reset_physics pulse, state PLAY. Assert reset_n=0 mid-scan: all outputs 0 asynchronously.
